ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle control sequencer for the 8-bit tiny CPU. It fetches instruction bytes, decodes them, and drives the 4-bit `alus` code consumed by the ALU, plus the register-file, bus, PC and memory strobes. It keeps the zero flag used by conditional jumps and parks the core on HALT.

## Interface
- No parameters: fixed 8-bit datapath, 4-bit opcode.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ir`  in  8  instruction register contents: [7:4] opcode, [3:2] Rd, [1:0] Rs.
- `mem_rdy`  in  1  memory read data valid this cycle.
- `alu_zero`  in  1  ALU result == 0, valid in EXEC.
- `alus`  out  4  ALU operation code.
- `rd_sel`  out  2  destination register select (= ir[3:2]).
- `rs_sel`  out  2  source register select (= ir[1:0]).
- `bus_src`  out  2  write-back source: 00 ALU, 01 MEM, 10 Rs.
- `reg_we`  out  1  register-file write strobe.
- `mem_rd`  out  1  memory read request (address = PC).
- `ir_load`  out  1  latch memory data into IR.
- `pc_inc`  out  1  PC <= PC+1.
- `pc_load`  out  1  PC <= memory data.
- `zflag`  out  1  registered zero flag.
- `halted`  out  1  core is in HALT.
- `illegal`  out  1  sticky: reserved opcode trapped (trap build only).

## Operation
- States: FETCH, DECODE, EXEC, OPND, HALT. Reset state FETCH.
- FETCH: `mem_rd`=1. When `mem_rdy`=1: `ir_load`=1, `pc_inc`=1, go DECODE. Otherwise stay (unbounded wait).
- DECODE routing by opcode:
  - 0001 ADD, 0010 SUB, 0011 INC, 0100 DEC, 0101 AND, 0110 OR, 0111 NOT, 1000 SHL -> EXEC.
  - 0000 NOP -> FETCH.
  - 1001 MOV -> EXEC.
  - 1010 LDI, 1011 JMP -> OPND.
  - 1100 JZ -> OPND if `zflag`=1; else `pc_inc`=1 (skip operand byte) and go FETCH.
  - 1111 HALT -> HALT.
  - 1101, 1110 -> see Configuration.
- EXEC, ALU ops: `alus`=opcode, `bus_src`=00, `reg_we`=1, `zflag`<=`alu_zero`; next FETCH.
- EXEC, MOV: `alus`=0000, `bus_src`=10, `reg_we`=1, `zflag` unchanged; next FETCH.
- OPND: `mem_rd`=1 until `mem_rdy`. In that cycle:
  - LDI: `bus_src`=01, `reg_we`=1, `pc_inc`=1.
  - JMP/JZ: `pc_load`=1, no `pc_inc`.
  - Then go FETCH.
- HALT: all strobes 0, `halted`=1; only `rst` exits.
- `rd_sel`/`rs_sel` are always IR fields. All strobes and `alus` are 0 in any state/op not listed above.
- `zflag` is changed only by the eight ALU ops.

## Timing
- Strobes are Mealy outputs of the registered state, `ir`, `zflag` and `mem_rdy`. `zflag`, `halted` and `illegal` are registered.
- Latency with `mem_rdy` tied high:
  - ALU op / MOV: 3 cycles.
  - LDI, JMP, taken JZ: 3 cycles.
  - NOP, untaken JZ: 2 cycles.
- Each cycle `mem_rdy` is low in FETCH or OPND adds 1 cycle.
- `pc_inc` and `pc_load` are never asserted in the same cycle.
- Reset: during the `rst` cycle all outputs are 0. After reset: state FETCH, `zflag`=0, `halted`=0, `illegal`=0.
- `rst` mid-wait or mid-instruction abandons the instruction; no write-back.
- `mem_rdy` high outside FETCH/OPND is ignored.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: opcodes 1101 and 1110 go to HALT and set `illegal`=1, held until reset.
- Not defined: 1101 and 1110 execute as NOP (DECODE -> FETCH). `illegal` is tied 0.

## Test plan
- Reset, then `ir`=0x14 (ADD R1,R0), `mem_rdy`=1, `alu_zero`=1 -> cycle 3 shows `alus`=0001, `reg_we`=1, `rd_sel`=01, `rs_sel`=00; `zflag`=1 next cycle.
- LDI R2 with `mem_rdy` low for 2 OPND cycles -> `mem_rd` held 2 cycles; then one cycle with `bus_src`=01, `reg_we`=1, `pc_inc`=1.
- JZ with `zflag`=0 -> DECODE `pc_inc`=1, no OPND read. JZ with `zflag`=1 -> OPND `pc_load`=1.
- `ir`=0xF0 -> `halted`=1 and no strobes for 10+ cycles. `rst` pulse -> FETCH with `mem_rd`=1 the cycle after.
- `ir`=0xD0 -> trap build: `halted`=1, `illegal`=1. Non-trap build: back to FETCH after 2 cycles, `illegal`=0.
- `rst` asserted during EXEC of SUB -> `reg_we`=0 in that cycle; `zflag` resets to 0.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit tiny CPU.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes 1101/1110 into HALT with a sticky illegal flag.
module ctrl_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic       mem_rdy,
    input  logic       alu_zero,
    output logic [3:0] alus,
    output logic [1:0] rd_sel,
    output logic [1:0] rs_sel,
    output logic [1:0] bus_src,
    output logic       reg_we,
    output logic       mem_rd,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       zflag,
    output logic       halted,
    output logic       illegal
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_OPND, S_HALT
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state;
    logic       zq;
    logic       hq;
    logic [3:0] op;
    logic       is_alu;

    assign op     = ir[7:4];
    assign is_alu = (op >= 4'h1) && (op <= 4'h8);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illq;
    assign illegal = illq & ~rst;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            zq    <= 1'b0;
            hq    <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illq  <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH:  if (mem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    if (is_alu || op == OP_MOV)           state <= S_EXEC;
                    else if (op == OP_LDI || op == OP_JMP) state <= S_OPND;
                    else if (op == OP_JZ)                  state <= zq ? S_OPND : S_FETCH;
                    else if (op == OP_HALT) begin
                        state <= S_HALT;
                        hq    <= 1'b1;
                    end
`ifdef CTRL_ILLEGAL_TRAP_EN
                    else if (op == 4'hD || op == 4'hE) begin
                        state <= S_HALT;
                        hq    <= 1'b1;
                        illq  <= 1'b1;
                    end
`endif
                    else state <= S_FETCH;
                end
                S_EXEC: begin
                    if (is_alu) zq <= alu_zero;
                    state <= S_FETCH;
                end
                S_OPND:   if (mem_rdy) state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Strobes are Mealy on the registered state; everything is forced low while rst is high.
    always_comb begin
        alus    = 4'h0;
        bus_src = 2'b00;
        reg_we  = 1'b0;
        mem_rd  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_rd  = 1'b1;
                    ir_load = mem_rdy;
                    pc_inc  = mem_rdy;
                end
                S_DECODE: if (op == OP_JZ && !zq) pc_inc = 1'b1;
                S_EXEC: begin
                    if (is_alu) begin
                        alus   = op;
                        reg_we = 1'b1;
                    end else if (op == OP_MOV) begin
                        bus_src = 2'b10;
                        reg_we  = 1'b1;
                    end
                end
                S_OPND: begin
                    mem_rd = 1'b1;
                    if (mem_rdy) begin
                        if (op == OP_LDI) begin
                            bus_src = 2'b01;
                            reg_we  = 1'b1;
                            pc_inc  = 1'b1;
                        end else begin
                            pc_load = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_sel = rst ? 2'b00 : ir[3:2];
    assign rs_sel = rst ? 2'b00 : ir[1:0];
    assign zflag  = zq & ~rst;
    assign halted = hq & ~rst;
endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: stimulus pushes per-cycle expected outputs, a negedge monitor checks them.
module tb_ctrl_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       mem_rdy = 1'b0;
    logic       alu_zero = 1'b0;
    logic [3:0] alus;
    logic [1:0] rd_sel, rs_sel, bus_src;
    logic       reg_we, mem_rd, ir_load, pc_inc, pc_load, zflag, halted, illegal;

    ctrl_seq dut (
        .clk(clk), .rst(rst), .ir(ir), .mem_rdy(mem_rdy), .alu_zero(alu_zero),
        .alus(alus), .rd_sel(rd_sel), .rs_sel(rs_sel), .bus_src(bus_src),
        .reg_we(reg_we), .mem_rd(mem_rd), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .zflag(zflag), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // strobe field order: reg_we, mem_rd, ir_load, pc_inc, pc_load
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] WE   = 5'b10000;
    localparam logic [4:0] MRD  = 5'b01000;
    localparam logic [4:0] FRDY = 5'b01110;
    localparam logic [4:0] PCI  = 5'b00010;
    localparam logic [4:0] PCL  = 5'b00001;

    typedef struct {
        string       name;
        logic [17:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [17:0] ev(input logic [7:0] i, input logic [3:0] a,
                                       input logic [1:0] b, input logic [4:0] s,
                                       input logic z, input logic h, input logic il);
        return {a, i[3:2], i[1:0], b, s, z, h, il};
    endfunction

    task automatic cyc(input string nm, input logic r, input logic [7:0] i,
                       input logic rdy, input logic az, input logic [17:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; ir = i; mem_rdy = rdy; alu_zero = az;
        x.name = nm;
        x.exp  = r ? 18'h0 : e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            logic [17:0] got;
            x   = sb.pop_front();
            got = {alus, rd_sel, rs_sel, bus_src, reg_we, mem_rd, ir_load, pc_inc, pc_load,
                   zflag, halted, illegal};
            tests++;
            if (got !== x.exp) begin
                fails++;
                $display("FAIL %s: got %b want %b", x.name, got, x.exp);
            end
        end
    end

    initial begin
        cyc("reset", 1, 8'h14, 1, 1, 18'h0);
        // ADD R1,R0 with zero result
        cyc("add_fetch",  0, 8'h14, 1, 1, ev(8'h14, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("add_decode", 0, 8'h14, 1, 1, ev(8'h14, 4'h0, 2'b00, NONE, 0, 0, 0));
        cyc("add_exec",   0, 8'h14, 1, 1, ev(8'h14, 4'h1, 2'b00, WE,   0, 0, 0));
        // LDI R2 with two stalled operand cycles; zflag now 1
        cyc("ldi_fetch",  0, 8'hA8, 1, 0, ev(8'hA8, 4'h0, 2'b00, FRDY, 1, 0, 0));
        cyc("ldi_decode", 0, 8'hA8, 1, 0, ev(8'hA8, 4'h0, 2'b00, NONE, 1, 0, 0));
        cyc("ldi_wait1",  0, 8'hA8, 0, 0, ev(8'hA8, 4'h0, 2'b00, MRD,  1, 0, 0));
        cyc("ldi_wait2",  0, 8'hA8, 0, 0, ev(8'hA8, 4'h0, 2'b00, MRD,  1, 0, 0));
        cyc("ldi_opnd",   0, 8'hA8, 1, 0, ev(8'hA8, 4'h0, 2'b01, WE | MRD | PCI, 1, 0, 0));
        // JZ taken
        cyc("jzt_fetch",  0, 8'hC0, 1, 0, ev(8'hC0, 4'h0, 2'b00, FRDY, 1, 0, 0));
        cyc("jzt_decode", 0, 8'hC0, 1, 0, ev(8'hC0, 4'h0, 2'b00, NONE, 1, 0, 0));
        cyc("jzt_opnd",   0, 8'hC0, 1, 0, ev(8'hC0, 4'h0, 2'b00, MRD | PCL, 1, 0, 0));
        // SUB R0,R1 nonzero -> clears zflag
        cyc("sub_fetch",  0, 8'h21, 1, 0, ev(8'h21, 4'h0, 2'b00, FRDY, 1, 0, 0));
        cyc("sub_decode", 0, 8'h21, 1, 0, ev(8'h21, 4'h0, 2'b00, NONE, 1, 0, 0));
        cyc("sub_exec",   0, 8'h21, 1, 0, ev(8'h21, 4'h2, 2'b00, WE,   1, 0, 0));
        // JZ untaken skips operand
        cyc("jzn_fetch",  0, 8'hC0, 1, 0, ev(8'hC0, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("jzn_decode", 0, 8'hC0, 1, 0, ev(8'hC0, 4'h0, 2'b00, PCI,  0, 0, 0));
        // MOV R1,R2: alu_zero high must not touch zflag
        cyc("mov_fetch",  0, 8'h96, 1, 1, ev(8'h96, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("mov_decode", 0, 8'h96, 1, 1, ev(8'h96, 4'h0, 2'b00, NONE, 0, 0, 0));
        cyc("mov_exec",   0, 8'h96, 1, 1, ev(8'h96, 4'h0, 2'b10, WE,   0, 0, 0));
        // NOP
        cyc("nop_fetch",  0, 8'h00, 1, 1, ev(8'h00, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("nop_decode", 0, 8'h00, 1, 1, ev(8'h00, 4'h0, 2'b00, NONE, 0, 0, 0));
        // JMP after one fetch stall
        cyc("jmp_wait",   0, 8'hB0, 0, 0, ev(8'hB0, 4'h0, 2'b00, MRD,  0, 0, 0));
        cyc("jmp_fetch",  0, 8'hB0, 1, 0, ev(8'hB0, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("jmp_decode", 0, 8'hB0, 1, 0, ev(8'hB0, 4'h0, 2'b00, NONE, 0, 0, 0));
        cyc("jmp_opnd",   0, 8'hB0, 1, 0, ev(8'hB0, 4'h0, 2'b00, MRD | PCL, 0, 0, 0));
        // reserved opcode 1101
        cyc("rsv_fetch",  0, 8'hD0, 1, 0, ev(8'hD0, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("rsv_decode", 0, 8'hD0, 1, 0, ev(8'hD0, 4'h0, 2'b00, NONE, 0, 0, 0));
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("rsv_trap",   0, 8'hD0, 1, 0, ev(8'hD0, 4'h0, 2'b00, NONE, 0, 1, 1));
        cyc("rsv_trap2",  0, 8'hD0, 1, 0, ev(8'hD0, 4'h0, 2'b00, NONE, 0, 1, 1));
        cyc("rsv_rst",    1, 8'hD0, 1, 0, 18'h0);
`endif
        // ADD sets zflag, then reset during SUB exec
        cyc("add2_fetch", 0, 8'h14, 1, 1, ev(8'h14, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("add2_dec",   0, 8'h14, 1, 1, ev(8'h14, 4'h0, 2'b00, NONE, 0, 0, 0));
        cyc("add2_exec",  0, 8'h14, 1, 1, ev(8'h14, 4'h1, 2'b00, WE,   0, 0, 0));
        cyc("sub2_fetch", 0, 8'h2D, 1, 1, ev(8'h2D, 4'h0, 2'b00, FRDY, 1, 0, 0));
        cyc("sub2_dec",   0, 8'h2D, 1, 1, ev(8'h2D, 4'h0, 2'b00, NONE, 1, 0, 0));
        cyc("sub2_rst",   1, 8'h2D, 1, 1, 18'h0);
        cyc("post_rst",   0, 8'h2D, 0, 1, ev(8'h2D, 4'h0, 2'b00, MRD,  0, 0, 0));
        // HALT parks the core, mem_rdy ignored
        cyc("hlt_fetch",  0, 8'hF0, 1, 0, ev(8'hF0, 4'h0, 2'b00, FRDY, 0, 0, 0));
        cyc("hlt_decode", 0, 8'hF0, 1, 0, ev(8'hF0, 4'h0, 2'b00, NONE, 0, 0, 0));
        for (int k = 0; k < 12; k++)
            cyc("halted", 0, 8'hF0, 1, 1, ev(8'hF0, 4'h0, 2'b00, NONE, 0, 1, 0));
        cyc("hlt_rst",    1, 8'hF0, 1, 0, 18'h0);
        cyc("hlt_exit",   0, 8'hF0, 0, 0, ev(8'hF0, 4'h0, 2'b00, MRD,  0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
